regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port arbiter between the tile's write sources and the banked register file. It accepts write requests from the N_CORES core write-back ports and the N_EXT_WR_PORTS external ports (N_WR_PORTS total) and decodes each address into a bank and an offset. Each cycle it grants at most one write per bank, round-robin among the contenders. The granted writes are driven to the bank write ports registered, one cycle later.

## Interface
Parameters:
- DATA_WIDTH, 16: register data width.
- N_CORES, 4: core write-back ports, occupying port indices 0..N_CORES-1.
- N_EXT_WR_PORTS, 1: external write ports, occupying indices N_CORES..N_WR_PORTS-1.
- N_BANK, 4: number of register banks.
- N_BANK_SIZE, 16: registers per bank; must be a power of two.
- Derived values, not overridable:
  - N_WR_PORTS = N_CORES + N_EXT_WR_PORTS.
  - OFF_W = $clog2(N_BANK_SIZE).
  - ADDR_W = $clog2(N_BANK*N_BANK_SIZE).

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous reset, active-high.
- wr_valid_i, in, N_WR_PORTS: per-port write request.
- wr_addr_i, in, N_WR_PORTS*ADDR_W: flat address; port p uses bits [p*ADDR_W +: ADDR_W].
- wr_data_i, in, N_WR_PORTS*DATA_WIDTH: flat write data.
- wr_ready_o, out, N_WR_PORTS: per-port accept, combinational.
- bank_wr_en_o, out, N_BANK: registered bank write strobe.
- bank_wr_addr_o, out, N_BANK*OFF_W: registered in-bank offset.
- bank_wr_data_o, out, N_BANK*DATA_WIDTH: registered write data.
- addr_err_o, out, 1: registered pulse on an out-of-range write.

## Operation
Address decode:
- bank = addr >> OFF_W.
- offset = addr[OFF_W-1:0].
- An address is out of range when bank >= N_BANK.

Arbitration, evaluated independently for each bank b:
- Contenders are the ports with wr_valid_i high and an in-range bank equal to b.
- Search starts at rr_ptr[b] and proceeds upward in port index, wrapping past N_WR_PORTS-1 to 0.
- The first contender found is granted.
- On a grant, rr_ptr[b] becomes (granted port + 1) mod N_WR_PORTS.
- With no grant, rr_ptr[b] holds.

Ready and transfer:
- wr_ready_o[p] = granted(p), or (wr_valid_i[p] and address out of range).
- wr_ready_o is combinational from wr_valid_i, wr_addr_i and rr_ptr; there is no path from outputs back into it.
- A transfer occurs on the rising edge when valid and ready are both high.
- Ungranted sources hold valid, address and data stable until granted.
- A source may drop valid without being granted; no state is left behind.

Out-of-range writes:
- Accepted the same cycle and dropped.
- addr_err_o is high for the next cycle.

Bank outputs:
- bank_wr_en_o[b] is registered high for exactly one cycle per granted write.
- Offset and data are captured from the granted port in the same cycle.
- When en is low, offset and data hold their previous values.

Same-address conflicts:
- Two ports writing the same address in one cycle are serialised: one per cycle, in round-robin order.
- The later grant wins in the bank.

Reset:
- bank_wr_en_o = 0, bank_wr_addr_o = 0, bank_wr_data_o = 0, addr_err_o = 0.
- All rr_ptr = 0.
- wr_ready_o is 0 while rst is high, regardless of valid.
- Reset asserted mid-stream cancels registered strobes on the next edge. Requests not granted are not retained.

## Timing
- Latency is exactly 1 cycle from accept edge to bank_wr_en_o high.
- Throughput is up to N_BANK writes per cycle when the contenders target distinct banks.
- Worst-case wait for a continuously valid port is N_WR_PORTS-1 cycles, since the round-robin is starvation-free.
- The rr_ptr update and the output register share the same edge.

## Configuration
- REGFILE_WR_ARB_STATS_EN defined:
  - Adds output conflict_cnt_o, 32 bits.
  - It increments by the number of (valid, in-range, not granted) ports in each cycle.
  - It saturates at 2^32-1 and is cleared by rst.
- REGFILE_WR_ARB_STATS_EN undefined:
  - The port and the counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then port 0 writes addr 0x13 data 0xBEEF → ready in the same cycle; next cycle bank_wr_en_o = 0b0010, bank 1 offset 3, data 0xBEEF.
- Ports 0..3 write addr 0x00, 0x10, 0x20, 0x30 simultaneously → all ready in one cycle; next cycle bank_wr_en_o = 0b1111.
- Ports 0, 1, 2 hold valid to bank 0 for 3 cycles starting from rr_ptr = 0 → grants in order 0, 1, 2 on consecutive cycles; rr_ptr[0] ends at 3; with stats enabled, the counter increases 2, then 1, then 0, for a total of 3.
- External port 4 contends with core ports 0..3, all on bank 2, continuously → port 4 is granted within 5 cycles and the grant order wraps 4 → 0.
- N_BANK=3 with port 1 writing addr 0x35 (bank 3) → ready immediately; no bank_wr_en; addr_err_o = 1 for one cycle.
- Port 2 is granted, and rst is asserted in the following cycle → bank_wr_en_o = 0 after that edge; wr_ready_o = 0 while rst is high; rr_ptr = 0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Routes write requests from the core write-back ports and the external write
// ports onto the banked register file. Each address is split into a bank and
// an in-bank offset. Every bank grants at most one write per cycle, picked
// round-robin among the ports that target it. The granted writes reach the bank
// write ports one cycle later, from registers.
//
// Optional feature: define REGFILE_WR_ARB_STATS_EN to add conflict_cnt_o. This
// saturating 32-bit counter adds up, each cycle, the valid in-range requests
// that were not granted.
//
// Handshake: a transfer happens on a rising edge where wr_valid_i[p] and
// wr_ready_o[p] are both high. A source that is not granted keeps valid,
// address and data stable, or it drops valid, which leaves no state behind.
// wr_ready_o is combinational from wr_valid_i, wr_addr_i and the round-robin
// pointers. It is held low while rst is high. An out-of-range address is
// accepted at once and dropped, and addr_err_o pulses for one cycle.

module regfile_wr_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int N_CORES        = 4,
  parameter int N_EXT_WR_PORTS = 1,
  parameter int N_BANK         = 4,
  parameter int N_BANK_SIZE    = 16,
  localparam int N_WR_PORTS    = N_CORES + N_EXT_WR_PORTS,
  localparam int OFF_W         = $clog2(N_BANK_SIZE),
  localparam int ADDR_W        = $clog2(N_BANK * N_BANK_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_WR_PORTS-1:0]        wr_valid_i,
  input  logic [N_WR_PORTS*ADDR_W-1:0] wr_addr_i,
  input  logic [N_WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
  output logic [N_WR_PORTS-1:0]        wr_ready_o,
  output logic [N_BANK-1:0]            bank_wr_en_o,
  output logic [N_BANK*OFF_W-1:0]      bank_wr_addr_o,
  output logic [N_BANK*DATA_WIDTH-1:0] bank_wr_data_o,
`ifdef REGFILE_WR_ARB_STATS_EN
  output logic [31:0]                  conflict_cnt_o,
`endif
  output logic                         addr_err_o
);

  localparam int PTR_W = (N_WR_PORTS > 1) ? $clog2(N_WR_PORTS) : 1;

  logic [ADDR_W-1:0]     port_addr [N_WR_PORTS];
  logic [ADDR_W-1:0]     port_bank [N_WR_PORTS];
  logic [N_WR_PORTS-1:0] addr_oor;
  logic [N_WR_PORTS-1:0] in_range_req;
  logic [N_WR_PORTS-1:0] contend [N_BANK];

  logic [PTR_W-1:0]      rr_ptr    [N_BANK];
  logic [N_BANK-1:0]     bank_gnt;
  logic [PTR_W-1:0]      gnt_next  [N_BANK];
  logic [OFF_W-1:0]      gnt_off   [N_BANK];
  logic [DATA_WIDTH-1:0] gnt_data  [N_BANK];
  logic [N_WR_PORTS-1:0] granted;

  // Split each port address into bank and offset, and build the per-bank contender masks
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      contend[b] = '0;
    end
    for (int p = 0; p < N_WR_PORTS; p++) begin
      port_addr[p]    = wr_addr_i[p*ADDR_W +: ADDR_W];
      port_bank[p]    = port_addr[p] >> OFF_W;
      addr_oor[p]     = (port_bank[p] >= ADDR_W'(N_BANK));
      in_range_req[p] = wr_valid_i[p] && !addr_oor[p];
      for (int b = 0; b < N_BANK; b++) begin
        contend[b][p] = in_range_req[p] && (port_bank[p] == ADDR_W'(b));
      end
    end
  end

  // Per-bank round-robin: the first contender at or after rr_ptr, wrapping, wins
  always_comb begin
    bank_gnt = '0;
    granted  = '0;
    for (int b = 0; b < N_BANK; b++) begin
      gnt_next[b] = '0;
      gnt_off[b]  = '0;
      gnt_data[b] = '0;
      for (int k = 0; k < N_WR_PORTS; k++) begin
        int idx;
        idx = int'(rr_ptr[b]) + k;
        if (idx >= N_WR_PORTS) idx = idx - N_WR_PORTS;
        if (!bank_gnt[b] && contend[b][idx]) begin
          bank_gnt[b]  = 1'b1;
          granted[idx] = 1'b1;
          gnt_next[b]  = (idx == N_WR_PORTS - 1) ? '0 : PTR_W'(idx + 1);
          gnt_off[b]   = port_addr[idx][OFF_W-1:0];
          gnt_data[b]  = wr_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Ready: granted in-range writes, plus out-of-range writes that get swallowed
  always_comb begin
    wr_ready_o = rst ? '0 : (granted | (wr_valid_i & addr_oor));
  end

  // Register the granted writes onto the bank ports and advance the winning banks' pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_wr_en_o   <= '0;
      bank_wr_addr_o <= '0;
      bank_wr_data_o <= '0;
      addr_err_o     <= 1'b0;
      for (int b = 0; b < N_BANK; b++) begin
        rr_ptr[b] <= '0;
      end
    end else begin
      bank_wr_en_o <= bank_gnt;
      addr_err_o   <= |(wr_valid_i & addr_oor);
      for (int b = 0; b < N_BANK; b++) begin
        if (bank_gnt[b]) begin
          bank_wr_addr_o[b*OFF_W +: OFF_W]           <= gnt_off[b];
          bank_wr_data_o[b*DATA_WIDTH +: DATA_WIDTH] <= gnt_data[b];
          rr_ptr[b]                                  <= gnt_next[b];
        end
      end
    end
  end

`ifdef REGFILE_WR_ARB_STATS_EN
  logic [31:0] miss_cnt;
  logic [32:0] cnt_sum;

  // Count the in-range requests that lost arbitration this cycle
  always_comb begin
    miss_cnt = '0;
    for (int p = 0; p < N_WR_PORTS; p++) begin
      miss_cnt = miss_cnt + {31'b0, in_range_req[p] & ~granted[p]};
    end
    cnt_sum = {1'b0, conflict_cnt_o} + {1'b0, miss_cnt};
  end

  // Saturating conflict accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_o <= '0;
    end else if (cnt_sum[32]) begin
      conflict_cnt_o <= '1;
    end else begin
      conflict_cnt_o <= cnt_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios with literal
// expectations, followed by constrained-random traffic compared each cycle
// against a behavioural model.
module tb_regfile_wr_arbiter;

  localparam int DW    = 16;
  localparam int NP    = 5;
  localparam int NB    = 4;
  localparam int NBS   = 16;
  localparam int OFF_W = 4;
  localparam int AW    = 6;
  localparam int EW    = NB + NB*OFF_W + NB*DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (default configuration)
  logic [NP-1:0]       wr_valid = '0;
  logic [NP*AW-1:0]    wr_addr  = '0;
  logic [NP*DW-1:0]    wr_data  = '0;
  logic [NP-1:0]       wr_ready;
  logic [NB-1:0]       bank_en;
  logic [NB*OFF_W-1:0] bank_addr;
  logic [NB*DW-1:0]    bank_data;
  logic                addr_err;
`ifdef REGFILE_WR_ARB_STATS_EN
  logic [31:0]         conflict_cnt;
  logic [31:0]         conflict_cnt3;
`endif

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready),
    .bank_wr_en_o(bank_en), .bank_wr_addr_o(bank_addr), .bank_wr_data_o(bank_data),
`ifdef REGFILE_WR_ARB_STATS_EN
    .conflict_cnt_o(conflict_cnt),
`endif
    .addr_err_o(addr_err)
  );

  // three-bank DUT, used only for the out-of-range scenario
  logic [NP-1:0]    v3 = '0;
  logic [NP*AW-1:0] a3 = '0;
  logic [NP*DW-1:0] d3 = '0;
  logic [NP-1:0]    ready3;
  logic [2:0]       en3;
  logic [11:0]      addr3;
  logic [47:0]      data3;
  logic             err3;

  regfile_wr_arbiter #(.N_BANK(3)) dut3 (
    .clk(clk), .rst(rst),
    .wr_valid_i(v3), .wr_addr_i(a3), .wr_data_i(d3),
    .wr_ready_o(ready3),
    .bank_wr_en_o(en3), .bank_wr_addr_o(addr3), .bank_wr_data_o(data3),
`ifdef REGFILE_WR_ARB_STATS_EN
    .conflict_cnt_o(conflict_cnt3),
`endif
    .addr_err_o(err3)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_ptr [NB];
  int              m_gnt [NB];
  logic [NB-1:0]   m_en;
  logic [OFF_W-1:0] m_off [NB];
  logic [DW-1:0]   m_dat [NB];
  logic            m_err;
  logic [31:0]     m_cnt;
  logic [NP-1:0]   m_acc;
  logic [EW-1:0]   exp_q[$];
  bit              model_live = 0;

  function automatic int p_addr(input int p);
    return int'(wr_addr[p*AW +: AW]);
  endfunction

  function automatic int p_bank(input int p);
    return p_addr(p) / NBS;
  endfunction

  // winner of each bank = valid in-range port with the smallest circular
  // distance from that bank's pointer
  function automatic void model_arb();
    for (int b = 0; b < NB; b++) begin
      int best;
      best = NP;
      m_gnt[b] = -1;
      for (int p = 0; p < NP; p++) begin
        if (wr_valid[p] && p_bank(p) == b) begin
          int d;
          d = (p - m_ptr[b] + NP) % NP;
          if (d < best) begin
            best = d;
            m_gnt[b] = p;
          end
        end
      end
    end
  endfunction

  function automatic logic [NP-1:0] model_ready();
    logic [NP-1:0] r;
    r = '0;
    if (rst) return r;
    model_arb();
    for (int b = 0; b < NB; b++) if (m_gnt[b] >= 0) r[m_gnt[b]] = 1'b1;
    for (int p = 0; p < NP; p++) if (wr_valid[p] && p_bank(p) >= NB) r[p] = 1'b1;
    return r;
  endfunction

  // advance the model at each edge and queue the outputs that must follow
  always @(posedge clk) begin
    logic [NB*OFF_W-1:0] off_flat;
    logic [NB*DW-1:0]    dat_flat;
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        m_ptr[b] = 0; m_off[b] = '0; m_dat[b] = '0;
      end
      m_en = '0; m_err = 1'b0; m_cnt = '0; m_acc = '0;
    end else begin
      int miss;
      longint sum;
      miss  = 0;
      m_acc = model_ready();
      m_err = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (wr_valid[p] && p_bank(p) >= NB) m_err = 1'b1;
        else if (wr_valid[p] && !m_acc[p]) miss++;
      end
      for (int b = 0; b < NB; b++) begin
        m_en[b] = (m_gnt[b] >= 0);
        if (m_gnt[b] >= 0) begin
          m_off[b] = OFF_W'(p_addr(m_gnt[b]) % NBS);
          m_dat[b] = wr_data[m_gnt[b]*DW +: DW];
          m_ptr[b] = (m_gnt[b] + 1) % NP;
        end
      end
      sum = longint'(m_cnt) + miss;
      m_cnt = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
    end
    for (int b = 0; b < NB; b++) begin
      off_flat[b*OFF_W +: OFF_W] = m_off[b];
      dat_flat[b*DW +: DW]       = m_dat[b];
    end
    exp_q.push_back({m_en, off_flat, dat_flat, m_err});
    model_live = 1;
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL exp_q: empty expected queue (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("bank_wr_en",   bank_en,   e[EW-1 -: NB]);
        check("bank_wr_addr", bank_addr, e[EW-NB-1 -: NB*OFF_W]);
        check("bank_wr_data", bank_data, e[NB*DW:1]);
        check("addr_err",     addr_err,  e[0]);
      end
      check("wr_ready", wr_ready, model_ready());
`ifdef REGFILE_WR_ARB_STATS_EN
      check("conflict_cnt", conflict_cnt, m_cnt);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input int a, input int d);
    wr_valid[p]          = v;
    wr_addr[p*AW +: AW]  = AW'(a);
    wr_data[p*DW +: DW]  = DW'(d);
  endtask

  task automatic clear_all();
    wr_valid = '0;
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NP-1:0] t3_rdy [3];
    logic [31:0]   t3_cnt [3];
    logic [NP-1:0] t4_rdy [6];
    t3_rdy = '{5'b00001, 5'b00010, 5'b00100};
    t3_cnt = '{32'd2, 32'd3, 32'd3};
    t4_rdy = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    step(); step(); step();
    @(negedge clk);
    check("reset_en",   bank_en,  4'b0000);
    check("reset_err",  addr_err, 1'b0);
    check("reset_ready", wr_ready, 5'b00000);
    step();
    rst = 1'b0;

    // single write to bank 1 offset 3
    set_port(0, 1'b1, 'h13, 'hBEEF);
    @(negedge clk);
    check("t1_ready", wr_ready, 5'b00001);
    step();
    clear_all();
    @(negedge clk);
    check("t1_en",   bank_en, 4'b0010);
    check("t1_off",  bank_addr[7:4], 4'h3);
    check("t1_data", bank_data[31:16], 16'hBEEF);

    // four ports into four distinct banks
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, p * 16, 'h1000 + p);
    @(negedge clk);
    check("t2_ready", wr_ready, 5'b01111);
    step();
    clear_all();
    @(negedge clk);
    check("t2_en",   bank_en, 4'b1111);
    check("t2_data3", bank_data[63:48], 16'h1003);

    // three ports on bank 0, each drops after its grant
    do_reset();
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, p + 1, 'h2000 + p);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_ready", wr_ready, t3_rdy[i]);
      step();
      wr_valid[i] = 1'b0;
`ifdef REGFILE_WR_ARB_STATS_EN
      @(negedge clk);
      check("t3_cnt", conflict_cnt, t3_cnt[i]);
`endif
    end

    // all five ports continuously on bank 2
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 'h20 + p, 'h3000 + p);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_ready", wr_ready, t4_rdy[i]);
      step();
    end
    clear_all();

    // grant then reset: strobe cancelled, ready gated, pointer cleared
    do_reset();
    set_port(2, 1'b1, 'h05, 'h1234);
    @(negedge clk);
    check("t6_ready", wr_ready, 5'b00100);
    step();
    rst = 1'b1;
    set_port(2, 1'b1, 'h15, 'h5678);
    @(negedge clk);
    check("t6_ready_rst", wr_ready, 5'b00000);
    check("t6_en_before", bank_en, 4'b0001);
    step();
    @(negedge clk);
    check("t6_en_after", bank_en, 4'b0000);
    check("t6_ready_rst2", wr_ready, 5'b00000);
    step();
    rst = 1'b0;
    clear_all();
    set_port(0, 1'b1, 'h00, 'h1111);
    set_port(3, 1'b1, 'h07, 'h3333);
    @(negedge clk);
    check("t6_ptr0", wr_ready, 5'b00001);
    step();
    clear_all();

    // out-of-range write on the three-bank instance
    v3 = 5'b00010;
    a3[1*AW +: AW] = 6'h35;
    d3[1*DW +: DW] = 16'hDEAD;
    @(negedge clk);
    check("t5_ready", ready3, 5'b00010);
    step();
    v3 = '0;
    @(negedge clk);
    check("t5_en",  en3,  3'b000);
    check("t5_err", err3, 1'b1);
    step();
    @(negedge clk);
    check("t5_err_pulse", err3, 1'b0);

    // constrained-random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!wr_valid[p] || m_acc[p]) begin
          if ($urandom_range(0, 99) < 60)
            set_port(p, 1'b1, $urandom_range(0, 3) * NBS + $urandom_range(0, 15), $urandom);
          else
            wr_valid[p] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          wr_valid[p] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    clear_all();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
